file_register_bus_sequencer: RTL

- Read-port sequencer for the file register's two shared tristate read buses, A (rs1) and B (rs2).
- Takes a register-pair read request and generates the one-hot enables that drive the per-register tristate buffers onto each bus.
- Inserts turnaround cycles whenever a bus changes driver, so two buffers never drive a bus at once.
- Tells the downstream operand latch when both buses are stable.

---
 rtl/file_register_bus_sequencer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/file_register_bus_sequencer.sv
// ---------------------------------------------------------------------------
// file_register_bus_sequencer
//
// Read-port sequencer for the register file's two shared tristate read buses,
// A (rs1) and B (rs2). It accepts a register-pair read request and produces
// the one-hot enables for the per-register tristate buffers on each bus.
// Whenever a bus changes driver, it inserts all-off turnaround cycles so that
// two buffers never fight on the bus. When both buses have settled, it tells
// the operand latch downstream with rsp_valid.
//
// Optional feature (compile-time macro FILE_REGISTER_BUS_RELEASE_EN):
//   When this macro is defined, both buses are released (all enables and zero
//   drivers off, parked drivers NONE) on the response handshake. Every later
//   request then takes the turnaround path.
//   When it is undefined (the default), buses stay parked on the last drivers.
//
// Parameters:
//   NUM_REGS    number of registers / tristate buffers per bus
//   ADDR_WIDTH  register address width
//   TURNAROUND  all-off cycles inserted on a driver change (1..15)
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   req_valid  read request present
//   req_ready  sequencer can accept a request (IDLE only)
//   rs1_addr   register driven onto bus A
//   rs2_addr   register driven onto bus B
//   a_enable   one-hot tristate enables, bus A (bit 0 never used)
//   b_enable   one-hot tristate enables, bus B (bit 0 never used)
//   a_zero     zero driver enable, bus A (r0 or out-of-range address)
//   b_zero     zero driver enable, bus B
//   rsp_valid  both buses driven and settled
//   rsp_ready  consumer has sampled the buses
// ---------------------------------------------------------------------------
module file_register_bus_sequencer #(
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int TURNAROUND = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic [NUM_REGS-1:0]   a_enable,
    output logic [NUM_REGS-1:0]   b_enable,
    output logic                  a_zero,
    output logic                  b_zero,
    output logic                  rsp_valid,
    input  logic                  rsp_ready
);

    typedef enum logic [1:0] {IDLE, TURN, DRIVE, VALID} state_t;

    state_t                state;
    logic [3:0]            turn_cnt;
    logic [ADDR_WIDTH-1:0] new_a;
    logic [ADDR_WIDTH-1:0] new_b;
    logic [ADDR_WIDTH-1:0] park_a;
    logic [ADDR_WIDTH-1:0] park_b;
    logic                  park_a_vld;   // 0 means the parked driver is NONE
    logic                  park_b_vld;

    // A driver is encoded as a register index; index 0 stands for the zero
    // driver, which covers both r0 and out-of-range addresses.
    function automatic logic [ADDR_WIDTH-1:0] map_drv(input logic [ADDR_WIDTH-1:0] addr);
        if (int'(addr) >= NUM_REGS)
            return '0;
        return addr;
    endfunction

    // Register enables only; the zero driver has its own output, so index 0
    // yields no enable bit and the one-of-{enables, zero} invariant holds.
    function automatic logic [NUM_REGS-1:0] decode(input logic [ADDR_WIDTH-1:0] idx);
        logic [NUM_REGS-1:0] oh;
        oh = '0;
        for (int i = 1; i < NUM_REGS; i++)
            oh[i] = (int'(idx) == i);
        return oh;
    endfunction

    logic [ADDR_WIDTH-1:0] drv_a;
    logic [ADDR_WIDTH-1:0] drv_b;
    logic                  a_chg;
    logic                  b_chg;
    logic                  accept;

    always_comb begin
        drv_a  = map_drv(rs1_addr);
        drv_b  = map_drv(rs2_addr);
        a_chg  = !park_a_vld || (drv_a != park_a);
        b_chg  = !park_b_vld || (drv_b != park_b);
        accept = req_valid && req_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            turn_cnt   <= '0;
            new_a      <= '0;
            new_b      <= '0;
            park_a     <= '0;
            park_b     <= '0;
            park_a_vld <= 1'b0;
            park_b_vld <= 1'b0;
            a_enable   <= '0;
            b_enable   <= '0;
            a_zero     <= 1'b0;
            b_zero     <= 1'b0;
            rsp_valid  <= 1'b0;
            req_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        new_a     <= drv_a;
                        new_b     <= drv_b;
                        req_ready <= 1'b0;
                        if (!a_chg && !b_chg) begin
                            // Same drivers as parked: buses are already
                            // driven, go straight to the settle cycle.
                            state <= DRIVE;
                        end else begin
                            state    <= TURN;
                            turn_cnt <= 4'(TURNAROUND);
                            // Only the bus whose driver changes is released;
                            // the other keeps driving its parked register.
                            if (a_chg) begin
                                a_enable <= '0;
                                a_zero   <= 1'b0;
                            end
                            if (b_chg) begin
                                b_enable <= '0;
                                b_zero   <= 1'b0;
                            end
                        end
                    end
                end

                TURN: begin
                    // The edge that ends the last turnaround cycle turns the
                    // new drivers on, so DRIVE is the first driven cycle.
                    if (turn_cnt <= 4'd1) begin
                        turn_cnt   <= '0;
                        state      <= DRIVE;
                        a_enable   <= decode(new_a);
                        b_enable   <= decode(new_b);
                        a_zero     <= (new_a == '0);
                        b_zero     <= (new_b == '0);
                        park_a     <= new_a;
                        park_b     <= new_b;
                        park_a_vld <= 1'b1;
                        park_b_vld <= 1'b1;
                    end else begin
                        turn_cnt <= turn_cnt - 4'd1;
                    end
                end

                DRIVE: begin
                    state     <= VALID;
                    rsp_valid <= 1'b1;
                end

                VALID: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
`ifdef FILE_REGISTER_BUS_RELEASE_EN
                        a_enable   <= '0;
                        b_enable   <= '0;
                        a_zero     <= 1'b0;
                        b_zero     <= 1'b0;
                        park_a_vld <= 1'b0;
                        park_b_vld <= 1'b0;
`else
                        // Buses stay parked on the current drivers.
`endif
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
